// File: rtl/i2c_slave_pkg.sv
// Shared constants for the APB-programmable I2C target: register word
// indices, STATUS bit positions and the bus FSM state encoding.
package i2c_slave_pkg;

  localparam logic [3:0] REG_CFG    = 4'h0;
  localparam logic [3:0] REG_RX     = 4'h1;
  localparam logic [3:0] REG_TX     = 4'h2;
  localparam logic [3:0] REG_STATUS = 4'h3;

  localparam int STAT_IRQ       = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_EMPTY  = 2;
  localparam int STAT_ADDRESSED = 3;
  localparam int STAT_RW        = 4;
  localparam int STAT_OVERRUN   = 5;
  localparam int STAT_NACK      = 6;
  localparam int STAT_STOP      = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_ACK,
    S_IGNORE
  } i2c_slv_state_e;

endpackage

// File: rtl/i2c_slave_bus_mon.sv
// SCL/SDA synchronizers and registered bus-event pulses; pad to pulse is
// three clocks. sda_o is the synchronized SDA level aligned with the pulses.
module i2c_slave_bus_mon (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;

  // Synchronizers reset to the idle-high bus level so reset release is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      scl_rise_q <= scl_sync_q[1] & ~scl_prev_q;
      scl_fall_q <= ~scl_sync_q[1] & scl_prev_q;
      start_q    <= scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
      stop_q     <= scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
    end
  end

  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign sda_o      = sda_prev_q;

endmodule

// File: rtl/apb_i2c_slave.sv
// APB-programmable I2C target: 7-bit address match, RX/TX byte registers,
// W1C status flags and an interrupt. Never stretches SCL.
module apb_i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      interrupt_o,
  input  logic                      scl_pad_i,
  output logic                      scl_pad_o,
  output logic                      scl_padoen_o,
  input  logic                      sda_pad_i,
  output logic                      sda_pad_o,
  output logic                      sda_padoen_o,
  output logic [2:0]                dbg_state_o
);

  logic scl_rise, scl_fall, bus_start, bus_stop, sda_in;

  i2c_slave_bus_mon u_bus_mon (
    .clk_i      (HCLK),
    .rst_ni     (HRESETn),
    .scl_i      (scl_pad_i),
    .sda_i      (sda_pad_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop),
    .sda_o      (sda_in)
  );

  i2c_slv_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, rx_q, rx_d, tx_q, tx_d;
  logic [6:0] own_addr_q, own_addr_d;
  logic en_q, en_d, ien_q, ien_d, rx_full_q, rx_full_d, tx_valid_q, tx_valid_d;
  logic irq_q, irq_d, addressed_q, addressed_d, rw_q, rw_d;
  logic overrun_q, overrun_d, nack_q, nack_d, stop_q, stop_d;
  logic sda_oe_q, sda_oe_d, phase_q, phase_d, ack_q, ack_d, intr_q;
  logic apb_wr, apb_rd, irq_set, do_load;
  logic [3:0] reg_idx;
  logic [7:0] load_byte;
  logic unused_apb;

  // APB: zero wait state; an access completes in the cycle PSEL & PENABLE is high.
  assign reg_idx    = PADDR[5:2];
  assign apb_wr     = PSEL & PENABLE & PWRITE;
  assign apb_rd     = PSEL & PENABLE & ~PWRITE;
  assign load_byte  = tx_valid_q ? tx_q : 8'hFF;
  assign unused_apb = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0], PWDATA[31:9]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    own_addr_d  = own_addr_q;
    en_d        = en_q;
    ien_d       = ien_q;
    rx_full_d   = rx_full_q;
    tx_valid_d  = tx_valid_q;
    irq_d       = irq_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    overrun_d   = overrun_q;
    nack_d      = nack_q;
    stop_d      = stop_q;
    sda_oe_d    = sda_oe_q;
    phase_d     = phase_q;
    ack_d       = ack_q;
    irq_set     = 1'b0;
    do_load     = 1'b0;

    if (apb_wr && reg_idx == REG_CFG) {ien_d, en_d, own_addr_d} = PWDATA[8:0];
    if (apb_wr && reg_idx == REG_STATUS) begin
      if (PWDATA[STAT_IRQ])     irq_d     = 1'b0;
      if (PWDATA[STAT_OVERRUN]) overrun_d = 1'b0;
      if (PWDATA[STAT_NACK])    nack_d    = 1'b0;
      if (PWDATA[STAT_STOP])    stop_d    = 1'b0;
    end
    // RX read clears before any commit below, so a same-cycle commit is accepted.
    if (apb_rd && reg_idx == REG_RX) rx_full_d = 1'b0;

    if (bus_stop) begin
      state_d     = S_IDLE;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
      phase_d     = 1'b0;
      if (addressed_q) begin
        stop_d  = 1'b1;
        irq_set = 1'b1;
      end
    end else if (bus_start) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else if (!en_q && state_q != S_IDLE && state_q != S_IGNORE) begin
      state_d  = S_IGNORE;
      sda_oe_d = 1'b0;
      phase_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_in};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_d[7:1] == own_addr_q) begin
              addressed_d = 1'b1;
              rw_d        = shift_d[0];
              state_d     = S_ADDR_ACK;
              irq_set     = 1'b1;
            end else begin
              addressed_d = 1'b0;
              state_d     = S_IGNORE;
            end
          end
        end
        // phase_q marks the ACK bit window, opened and closed by successive SCL falls.
        S_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            phase_d  = 1'b1;
            sda_oe_d = 1'b1;
          end else begin
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            if (rw_q) begin
              do_load = 1'b1;
            end else begin
              state_d   = S_WRITE;
              bit_cnt_d = 3'd0;
            end
          end
        end
        S_WRITE: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_in};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_WRITE_ACK;
            if (!rx_full_d) begin
              rx_d      = shift_d;
              rx_full_d = 1'b1;
              irq_set   = 1'b1;
              ack_d     = 1'b1;
            end else begin
              overrun_d = 1'b1;
              ack_d     = 1'b0;
            end
          end
        end
        S_WRITE_ACK: if (scl_fall) begin
          if (!phase_q) begin
            phase_d  = 1'b1;
            sda_oe_d = ack_q;
          end else begin
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            state_d   = S_WRITE;
            bit_cnt_d = 3'd0;
          end
        end
        S_READ: if (scl_fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            state_d  = S_READ_ACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        S_READ_ACK: if (scl_rise) begin
          if (!sda_in) begin
            phase_d = 1'b1;
          end else begin
            nack_d  = 1'b1;
            state_d = S_IGNORE;
          end
        end else if (scl_fall && phase_q) begin
          phase_d = 1'b0;
          do_load = 1'b1;
        end
        default: ;
      endcase
    end

    // The shifter load sees the old TX/tx_valid; a same-cycle TX write lands after it.
    if (do_load) begin
      shift_d   = load_byte;
      sda_oe_d  = ~load_byte[7];
      bit_cnt_d = 3'd0;
      state_d   = S_READ;
      if (tx_valid_q) begin
        tx_valid_d = 1'b0;
        irq_set    = 1'b1;
      end
    end
    if (apb_wr && reg_idx == REG_TX) begin
      tx_d       = PWDATA[7:0];
      tx_valid_d = 1'b1;
    end
    if (irq_set) irq_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      own_addr_q  <= 7'h00;
      en_q        <= 1'b0;
      ien_q       <= 1'b0;
      rx_full_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      irq_q       <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      overrun_q   <= 1'b0;
      nack_q      <= 1'b0;
      stop_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      phase_q     <= 1'b0;
      ack_q       <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      own_addr_q  <= own_addr_d;
      en_q        <= en_d;
      ien_q       <= ien_d;
      rx_full_q   <= rx_full_d;
      tx_valid_q  <= tx_valid_d;
      irq_q       <= irq_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      overrun_q   <= overrun_d;
      nack_q      <= nack_d;
      stop_q      <= stop_d;
      sda_oe_q    <= sda_oe_d;
      phase_q     <= phase_d;
      ack_q       <= ack_d;
      intr_q      <= irq_q & ien_q;
    end
  end

  always_comb begin
    PRDATA = 32'h0;
    case (reg_idx)
      REG_CFG:    PRDATA[8:0] = {ien_q, en_q, own_addr_q};
      REG_RX:     PRDATA[7:0] = rx_q;
      REG_TX:     PRDATA[7:0] = tx_q;
      REG_STATUS: PRDATA[7:0] = {stop_q, nack_q, overrun_q, rw_q, addressed_q,
                                 ~tx_valid_q, rx_full_q, irq_q};
      default: ;
    endcase
  end

  assign PREADY       = 1'b1;
  assign PSLVERR      = 1'b0;
  assign interrupt_o  = intr_q;
  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = ~sda_oe_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_apb_i2c_slave.sv
// Bench for apb_i2c_slave: an open-drain I2C master model plus APB tasks,
// with a byte scoreboard for ACK bits, bus read data and RX contents.
module tb_apb_i2c_slave;
  import i2c_slave_pkg::*;

  localparam int Q = 10;
  localparam logic [11:0] A_CFG = 12'h000, A_RX = 12'h004, A_TX = 12'h008, A_ST = 12'h00C;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, interrupt_o;
  logic        scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [2:0]  dbg_state;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        scl_line, sda_line;

  int errors = 0;
  int checks = 0;
  int drive_cnt = 0;
  logic [7:0] exp_q[$];

  assign scl_line = scl_m & (scl_padoen_o | scl_pad_o);
  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  apb_i2c_slave #(.APB_ADDR_WIDTH(12)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .interrupt_o(interrupt_o),
    .scl_pad_i(scl_line), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
    .sda_pad_i(sda_line), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .dbg_state_o(dbg_state)
  );

  // clock / reset / watchdog
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) if (!sda_padoen_o) drive_cnt <= drive_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [7:0] got);
    if (exp_q.size() == 0) check({tag, " queue_empty"}, 32'(exp_q.size()), 32'd1);
    else check(tag, {24'h0, got}, {24'h0, exp_q.pop_front()});
  endtask

  // APB driver
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK);
    d = PRDATA;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(tag, d, exp);
  endtask

  // I2C master driver
  task automatic wait_q();
    repeat (Q) @(posedge HCLK);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_line);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack_line);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] b);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bit_v);
      b[i] = bit_v;
    end
    send_bit(~master_ack);
  endtask

  initial begin
    logic [7:0] b;
    logic a;
    int d0;

    repeat (3) @(posedge HCLK); #1;
    check("rst_sda_padoen", sda_padoen_o, 1);
    check("rst_scl_padoen", scl_padoen_o, 1);
    check("rst_pads", {scl_pad_o, sda_pad_o}, 0);
    check("rst_irq_pin", interrupt_o, 0);
    check("rst_pready_pslverr", {PREADY, PSLVERR}, 2'b10);
    check("rst_state", dbg_state, S_IDLE);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK); #1;
    check_reg("rst_cfg", A_CFG, 0);
    check_reg("rst_status", A_ST, 32'h04);
    check_reg("rst_rx", A_RX, 0);
    check_reg("undecoded", 12'h010, 0);

    // write transfer to 0x3A with EN and IEN
    apb_write(A_CFG, 32'h1BA);
    i2c_start();
    exp_q.push_back(8'h00); send_byte(8'h74, a); sb_pop("wr_addr_ack", {7'h0, a});
    exp_q.push_back(8'h00); send_byte(8'h5C, a); sb_pop("wr_data_ack", {7'h0, a});
    i2c_stop();
    check_reg("wr_status", A_ST, 32'h87);
    check("wr_irq_pin", interrupt_o, 1);
    check_reg("wr_rx", A_RX, 32'h5C);
    apb_write(A_ST, 32'hE1);
    check_reg("wr_status_clr", A_ST, 32'h04);
    check("wr_irq_pin_clr", interrupt_o, 0);

    // random write bytes through the RX scoreboard
    for (int k = 0; k < 3; k++) begin
      logic [31:0] rd;
      b = 8'($urandom_range(0, 255));
      i2c_start();
      exp_q.push_back(8'h00); send_byte(8'h74, a); sb_pop("rnd_addr_ack", {7'h0, a});
      exp_q.push_back(8'h00); send_byte(b, a);     sb_pop("rnd_data_ack", {7'h0, a});
      i2c_stop();
      exp_q.push_back(b);
      apb_read(A_RX, rd);
      sb_pop("rnd_rx", rd[7:0]);
    end
    apb_write(A_ST, 32'hE1);

    // address miss
    d0 = drive_cnt;
    i2c_start();
    exp_q.push_back(8'h01); send_byte(8'h76, a); sb_pop("miss_ack", {7'h0, a});
    check("miss_state", dbg_state, S_IGNORE);
    i2c_stop();
    check("miss_no_drive", drive_cnt, d0);
    check_reg("miss_status", A_ST, 32'h04);
    check("miss_irq_pin", interrupt_o, 0);

    // read transfer: 0xA5 from TX, then 0xFF filler, master NACKs the second
    apb_write(A_TX, 32'hA5);
    check_reg("rd_tx_loaded", A_ST, 32'h00);
    i2c_start();
    exp_q.push_back(8'h00); send_byte(8'h75, a); sb_pop("rd_addr_ack", {7'h0, a});
    exp_q.push_back(8'hA5); recv_byte(1'b1, b); sb_pop("rd_byte0", b);
    exp_q.push_back(8'hFF); recv_byte(1'b0, b); sb_pop("rd_byte1", b);
    i2c_stop();
    check_reg("rd_status", A_ST, 32'hD5);
    apb_write(A_ST, 32'hE1);
    check_reg("rd_status_clr", A_ST, 32'h14);

    // overrun: second data byte without an RX read
    i2c_start();
    exp_q.push_back(8'h00); send_byte(8'h74, a); sb_pop("ovr_addr_ack", {7'h0, a});
    exp_q.push_back(8'h00); send_byte(8'h11, a); sb_pop("ovr_ack1", {7'h0, a});
    exp_q.push_back(8'h01); send_byte(8'h22, a); sb_pop("ovr_nack2", {7'h0, a});
    i2c_stop();
    check_reg("ovr_status", A_ST, 32'hA7);
    check_reg("ovr_rx", A_RX, 32'h11);
    apb_write(A_ST, 32'hE1);

    // repeated start flips direction without a STOP
    apb_write(A_TX, 32'h3C);
    i2c_start();
    exp_q.push_back(8'h00); send_byte(8'h74, a); sb_pop("rs_addr_w_ack", {7'h0, a});
    exp_q.push_back(8'h00); send_byte(8'h10, a); sb_pop("rs_data_ack", {7'h0, a});
    i2c_start();
    exp_q.push_back(8'h00); send_byte(8'h75, a); sb_pop("rs_addr_r_ack", {7'h0, a});
    check_reg("rs_status_mid", A_ST, 32'h1F);
    exp_q.push_back(8'h3C); recv_byte(1'b0, b); sb_pop("rs_rd_byte", b);
    i2c_stop();
    check_reg("rs_status", A_ST, 32'hD7);
    check_reg("rs_rx", A_RX, 32'h10);
    apb_write(A_ST, 32'hE1);
    check_reg("rs_status_clr", A_ST, 32'h14);
    check("rs_irq_pin", interrupt_o, 0);

    // reset in the middle of a read byte
    apb_write(A_TX, 32'h0F);
    i2c_start();
    exp_q.push_back(8'h00); send_byte(8'h75, a); sb_pop("mr_addr_ack", {7'h0, a});
    recv_bit(a); check("mr_bit7", a, 0);
    recv_bit(a); check("mr_bit6", a, 0);
    check("mr_driving", sda_padoen_o, 0);
    HRESETn = 1'b0;
    #1;
    check("mr_sda_padoen", sda_padoen_o, 1);
    check("mr_irq_pin", interrupt_o, 0);
    check("mr_state", dbg_state, S_IDLE);
    check("mr_scl_pads", {scl_padoen_o, scl_pad_o, sda_pad_o}, 3'b100);
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
    HRESETn = 1'b1;
    repeat (3) @(posedge HCLK); #1;
    check_reg("mr_cfg", A_CFG, 0);
    check_reg("mr_status", A_ST, 32'h04);
    check_reg("mr_tx", A_TX, 0);
    check("mr_sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_i2c_slave.md
# apb_i2c_slave

APB-programmable I2C target (slave) that responds to an external I2C master on a 7-bit address. It receives write bytes into an RX register and supplies read bytes from a TX register. It raises an interrupt on byte and bus events. It sits on the same APB peripheral bus as the I2C master and shares its pad-control convention: `*_padoen_o` = 0 drives the line, pad outputs are open-drain low.

## Interface
- `APB_ADDR_WIDTH`, 12, APB address width; registers decoded from `PADDR[5:2]`.
- `HCLK` in 1 — the single clock. Reset is asynchronous, active-low, on `HRESETn`.
- `HRESETn` in 1 — asynchronous, active-low reset.
- `PADDR` in APB_ADDR_WIDTH — register address.
- `PWDATA` in 32 — write data.
- `PWRITE` in 1 — write strobe.
- `PSEL` in 1 — select.
- `PENABLE` in 1 — access phase.
- `PRDATA` out 32 — combinational read data; 0 for undecoded addresses.
- `PREADY` out 1 — tied 1.
- `PSLVERR` out 1 — tied 0.
- `interrupt_o` out 1 — registered `irq_flag & IEN`.
- `scl_pad_i` in 1 — SCL pad input.
- `scl_pad_o` out 1 — tied 0.
- `scl_padoen_o` out 1 — tied 1 (no clock stretching).
- `sda_pad_i` in 1 — SDA pad input.
- `sda_pad_o` out 1 — tied 0.
- `sda_padoen_o` out 1 — 0 pulls SDA low.

## Operation
- **Registers** (write on `PSEL & PENABLE & PWRITE`):
  - 0x00 CFG: [6:0] own address, [7] EN, [8] IEN.
  - 0x04 RX: RO; a read with `PSEL & PENABLE & !PWRITE` clears `rx_full`.
  - 0x08 TX: write loads the byte and sets `tx_valid`.
  - 0x0C STATUS: [0] irq, [1] rx_full, [2] tx_empty (=!tx_valid), [3] addressed, [4] rw, [5] overrun, [6] nack, [7] stop. Writing 1 to bits 0/5/6/7 clears them (W1C).
- **Bus monitor:** 2-flop synchronizers on SCL/SDA, then edge detect. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- **FSM states:** IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- **IDLE:** START goes to ADDR with bit count 0.
- **ADDR:** shift SDA MSB-first on each SCL rise. After the 8th rise:
  - If EN and `shift[7:1]` equals own address: `addressed`=1, `rw`=`shift[0]`, go to ADDR_ACK, set irq.
  - Otherwise go to IGNORE.
- **ADDR_ACK:** drive SDA low from the next SCL fall to the following SCL fall. At that closing fall:
  - `rw`=1: go to READ and load the shifter with TX if `tx_valid` (clearing `tx_valid` and setting irq), else with 0xFF.
  - `rw`=0: go to WRITE.
- **WRITE:** 8 SCL rises, then commit:
  - If `rx_full`=0: RX <= byte, `rx_full`=1, irq, ACK.
  - Else: NACK (release SDA), set overrun.
  - Either way go to WRITE_ACK. At the closing SCL fall, return to WRITE.
- **READ:** drive bit 7 at entry, then the next bit on each SCL fall (SDA low for 0, released for 1). After the 8th bit's SCL fall, release SDA and go to READ_ACK.
- **READ_ACK:** sample SDA on SCL rise.
  - ACK: at the next fall, reload the shifter (same rule as ADDR_ACK) and go to READ.
  - NACK: set nack, go to IGNORE.
- **IGNORE:** SDA released; wait for START/STOP.
- **START in any state** → ADDR (repeated start).
- **STOP in any state** → IDLE, `addressed`=0, SDA released; if `addressed` was 1, set stop and irq.
- **EN cleared mid-transfer** → IGNORE immediately, SDA released.
- **Simultaneous events:**
  - RX read in the same cycle as a commit: read clears first, so the commit is accepted (`rx_full` ends at 1, new data, no overrun).
  - TX write in the same cycle as a shifter load: the load uses the old contents and `tx_valid` state; the new write sets `tx_valid` afterwards.
  - irq set and W1C in the same cycle: set wins.

## Timing
- **Reset values:** all registers 0, state IDLE. `sda_padoen_o`=1, `scl_padoen_o`=1, `sda_pad_o`=`scl_pad_o`=0, `interrupt_o`=0, `PREADY`=1, `PSLVERR`=0.
- **Input latency:** pad to internal edge event is 3 HCLK cycles (2 synchronizer + 1 edge register).
- **SDA drive latency:** `sda_padoen_o` changes 1 cycle after the internal SCL-fall event, giving ≥3 HCLK of data hold.
- **Clock ratio:** HCLK ≥ 16× SCL required.
- **APB:** zero wait state. Register writes and flag updates are visible the next cycle. `interrupt_o` lags `irq_flag` by 1 cycle.
- **Bit counter:** 3 bits; wraps 7→0 at the byte boundary.

## Structure
- Package `i2c_slave_pkg`: register offset constants, STATUS bit indices, `i2c_slv_state_e` enum.
- Sub-module `i2c_slave_bus_mon`: synchronizers plus `scl_rise`, `scl_fall`, `start`, `stop` pulses.
- Top level holds the APB registers and the FSM.

## Test plan
- **Write transfer:** own address 0x3A, EN=1; master writes START, 0x74, 0x5C, STOP → ACK on both bytes, RX=0x5C, rx_full=1, stop=1, `interrupt_o`=1 with IEN set.
- **Address miss:** master addresses 0x3B → SDA never driven, state IGNORE, no irq.
- **Read transfer:** TX=0xA5, master reads 2 bytes (ACK then NACK) → bus sees 0xA5 then 0xFF, tx_empty=1, nack=1.
- **Overrun:** two write bytes without an RX read → second byte NACKed, overrun=1, RX holds the first byte.
- **Repeated start:** write 0x74, 0x10, then Sr with 0x75 → direction flips to read with no intervening STOP. Also: W1C of STATUS=0xE1 clears irq/overrun/nack/stop.
- **Reset mid-transfer:** assert `HRESETn` during a read byte → `sda_padoen_o`=1 immediately and all outputs return to their reset values.
